// File: rtl/pipelined_mac.sv
// Pipelined unsigned multiply-accumulate with valid/ready handshakes and full backpressure.
// Optional feature macro: MAC_SATURATE_EN (clamp accumulate overflow instead of wrapping).
module pipelined_mac #(
    parameter int WIDTH_A     = 8,
    parameter int WIDTH_B     = 8,
    parameter int ACC_WIDTH   = 20,
    parameter int PIPE_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH_A-1:0]   in_A,
    input  logic [WIDTH_B-1:0]   in_B,
    input  logic                 in_acc,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [ACC_WIDTH-1:0] out_P,
    output logic                 out_ovf,
    output logic                 out_valid,
    input  logic                 out_ready
);

    localparam int PW = WIDTH_A + WIDTH_B;

    logic                 stall;

    logic [WIDTH_A-1:0]   opA_q;
    logic [WIDTH_B-1:0]   opB_q;
    logic                 accFlag0_q;
    logic                 valid0_q;

    logic [ACC_WIDTH-1:0] prod_q [1:PIPE_STAGES];
    logic [PIPE_STAGES:1] prodAcc_q;
    logic [PIPE_STAGES:1] prodValid_q;

    logic [PW-1:0]        mulRaw;
    logic [ACC_WIDTH-1:0] mulExt;

    logic [ACC_WIDTH-1:0] accum_q, accum_d;
    logic                 ovf_q, ovf_d;
    logic                 outValid_q, outValid_d;
    logic [ACC_WIDTH:0]   sum;
    logic                 carry;

    assign stall     = outValid_q && !out_ready;
    assign in_ready  = !stall;
    assign out_P     = accum_q;
    assign out_ovf   = ovf_q;
    assign out_valid = outValid_q;

    assign mulRaw = opA_q * opB_q;
    assign mulExt = ACC_WIDTH'(mulRaw);

    // Operand and product stages all advance together and freeze as a unit on stall.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            opA_q       <= '0;
            opB_q       <= '0;
            accFlag0_q  <= 1'b0;
            valid0_q    <= 1'b0;
            prodAcc_q   <= '0;
            prodValid_q <= '0;
            for (int i = 1; i <= PIPE_STAGES; i++) begin
                prod_q[i] <= '0;
            end
        end else if (!stall) begin
            opA_q          <= in_A;
            opB_q          <= in_B;
            accFlag0_q     <= in_acc;
            valid0_q       <= in_valid;
            prod_q[1]      <= mulExt;
            prodAcc_q[1]   <= accFlag0_q;
            prodValid_q[1] <= valid0_q;
            for (int i = 2; i <= PIPE_STAGES; i++) begin
                prod_q[i]      <= prod_q[i-1];
                prodAcc_q[i]   <= prodAcc_q[i-1];
                prodValid_q[i] <= prodValid_q[i-1];
            end
        end
    end

    assign sum   = {1'b0, accum_q} + {1'b0, prod_q[PIPE_STAGES]};
    assign carry = sum[ACC_WIDTH];

    always_comb begin
        accum_d    = accum_q;
        ovf_d      = ovf_q;
        outValid_d = outValid_q;
        if (!stall) begin
            outValid_d = prodValid_q[PIPE_STAGES];
            if (prodValid_q[PIPE_STAGES]) begin
                if (!prodAcc_q[PIPE_STAGES]) begin
                    accum_d = prod_q[PIPE_STAGES];
                    ovf_d   = 1'b0;
                end else begin
`ifdef MAC_SATURATE_EN
                    // Once clamped, further adds carry again (or add zero), so the run stays pinned.
                    if (carry) begin
                        accum_d = '1;
                        ovf_d   = 1'b1;
                    end else begin
                        accum_d = sum[ACC_WIDTH-1:0];
                    end
`else
                    accum_d = sum[ACC_WIDTH-1:0];
                    ovf_d   = ovf_q | carry;
`endif
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            accum_q    <= '0;
            ovf_q      <= 1'b0;
            outValid_q <= 1'b0;
        end else begin
            accum_q    <= accum_d;
            ovf_q      <= ovf_d;
            outValid_q <= outValid_d;
        end
    end

endmodule

// File: tb/tb_pipelined_mac.sv
// Directed self-checking bench for pipelined_mac (default parameters, either MAC_SATURATE_EN build).
module tb_pipelined_mac;

    logic        clk;
    logic        rst;
    logic [7:0]  in_A;
    logic [7:0]  in_B;
    logic        in_acc;
    logic        in_valid;
    logic        in_ready;
    logic [19:0] out_P;
    logic        out_ovf;
    logic        out_valid;
    logic        out_ready;

    int total = 0;
    int bad   = 0;

    logic [19:0] seenP[$];
    logic        seenOvf[$];

    pipelined_mac #(
        .WIDTH_A(8), .WIDTH_B(8), .ACC_WIDTH(20), .PIPE_STAGES(2)
    ) dut (
        .clk(clk), .rst(rst),
        .in_A(in_A), .in_B(in_B), .in_acc(in_acc), .in_valid(in_valid),
        .in_ready(in_ready),
        .out_P(out_P), .out_ovf(out_ovf), .out_valid(out_valid),
        .out_ready(out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Output beats are logged mid-cycle whenever the next edge will consume them.
    always @(negedge clk) begin
        if (rst && out_valid && out_ready) begin
            seenP.push_back(out_P);
            seenOvf.push_back(out_ovf);
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s actual=%0d expected=%0d", tag, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b, input logic acc);
        logic accepted;
        int   tries;
        accepted = 1'b0;
        tries    = 0;
        in_A     = a;
        in_B     = b;
        in_acc   = acc;
        in_valid = 1'b1;
        while (!accepted && tries < 20) begin
            #1;
            accepted = in_ready;
            tick();
            tries++;
        end
        if (!accepted) checkOutput("accept_timeout", 0, 1);
    endtask

    localparam logic [19:0] WRAP17 = 20'd56849;
    localparam logic [19:0] SAT17  = 20'd1048575;

    logic [7:0] pat  [6] = '{1, 0, 1, 1, 0, 1};
    int         bVal [4] = '{2, 3, 4, 5};
    int         bExp [4] = '{2, 5, 9, 14};
    int         bp   [5] = '{1, 4, 9, 16, 25};

    initial begin
        logic accepted;
        int   idx, cycles, stallLeft, bi, oi, j;
        logic stallStarted;
        logic [19:0] expP;
        logic        expV;

        rst       = 1'b0;
        in_A      = 8'($urandom);
        in_B      = 8'($urandom);
        in_acc    = 1'($urandom);
        in_valid  = 1'($urandom);
        out_ready = 1'($urandom);
        #1;
        checkOutput("rst_P", out_P, 0);
        checkOutput("rst_ovf", out_ovf, 0);
        checkOutput("rst_valid", out_valid, 0);
        checkOutput("rst_in_ready", in_ready, 1);

        in_valid  = 1'b0;
        out_ready = 1'b1;
        #13;
        rst = 1'b1;
        tick();

        // Single load beat: 200*100 with three-edge latency.
        applyStimulus(8'd200, 8'd100, 1'b0);
        in_valid = 1'b0;
        tick();
        tick();
        checkOutput("load_early_valid", out_valid, 0);
        tick();
        checkOutput("load_valid", out_valid, 1);
        checkOutput("load_P", out_P, 20000);
        checkOutput("load_ovf", out_ovf, 0);
        tick();
        checkOutput("load_valid_drop", out_valid, 0);

        // Load 255*255, 16 accumulates, then a fresh load of 2*3.
        seenP.delete();
        seenOvf.delete();
        applyStimulus(8'd255, 8'd255, 1'b0);
        for (int i = 0; i < 16; i++) applyStimulus(8'd255, 8'd255, 1'b1);
        applyStimulus(8'd2, 8'd3, 1'b0);
        in_valid = 1'b0;
        repeat (6) tick();
        checkOutput("acc_count", seenP.size(), 18);
        if (seenP.size() == 18) begin
            checkOutput("acc_first", seenP[0], 65025);
            checkOutput("acc_16_P", seenP[15], 1040400);
            checkOutput("acc_16_ovf", seenOvf[15], 0);
`ifdef MAC_SATURATE_EN
            checkOutput("acc_17_P", seenP[16], SAT17);
`else
            checkOutput("acc_17_P", seenP[16], WRAP17);
`endif
            checkOutput("acc_17_ovf", seenOvf[16], 1);
            checkOutput("reload_P", seenP[17], 6);
            checkOutput("reload_ovf", seenOvf[17], 0);
        end

        // Backpressure: stall four cycles from the first output.
        seenP.delete();
        seenOvf.delete();
        idx          = 0;
        cycles       = 0;
        stallLeft    = 0;
        stallStarted = 1'b0;
        while (idx < 5 && cycles < 40) begin
            if (out_valid && !stallStarted) begin
                stallStarted = 1'b1;
                stallLeft    = 4;
            end
            if (stallLeft > 0) begin
                out_ready = 1'b0;
                stallLeft--;
            end else begin
                out_ready = 1'b1;
            end
            in_valid = 1'b1;
            in_A     = 8'(idx + 1);
            in_B     = 8'(idx + 1);
            in_acc   = 1'b0;
            #1;
            if (!out_ready) begin
                checkOutput("bp_in_ready", in_ready, 0);
                checkOutput("bp_hold_P", out_P, 1);
            end
            accepted = in_ready;
            tick();
            if (accepted) idx++;
            cycles++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (8) tick();
        checkOutput("bp_stalled", stallStarted, 1);
        checkOutput("bp_count", seenP.size(), 5);
        if (seenP.size() == 5) begin
            for (int i = 0; i < 5; i++) checkOutput($sformatf("bp_out%0d", i), seenP[i], bp[i]);
        end

        // Bubbles: valid pattern 1,0,1,1,0,1 reappears three edges later.
        expP = 20'd25;
        bi   = 0;
        oi   = 0;
        for (int k = 0; k < 11; k++) begin
            if (k < 6 && pat[k] != 0) begin
                in_valid = 1'b1;
                in_A     = 8'(bVal[bi]);
                in_B     = 8'd1;
                in_acc   = (bi != 0);
                bi++;
            end else begin
                in_valid = 1'b0;
            end
            tick();
            j    = k - 3;
            expV = 1'b0;
            if (j >= 0 && j < 6 && pat[j] != 0) begin
                expV = 1'b1;
                expP = 20'(bExp[oi]);
                oi++;
            end
            checkOutput($sformatf("bub_valid%0d", k), out_valid, expV);
            checkOutput($sformatf("bub_P%0d", k), out_P, expP);
        end
        in_valid = 1'b0;

        // Mid-stream reset with three beats in flight.
        applyStimulus(8'd9, 8'd9, 1'b0);
        applyStimulus(8'd10, 8'd10, 1'b0);
        applyStimulus(8'd11, 8'd11, 1'b0);
        in_valid = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        checkOutput("mid_rst_P", out_P, 0);
        checkOutput("mid_rst_valid", out_valid, 0);
        checkOutput("mid_rst_in_ready", in_ready, 1);
        #2;
        rst = 1'b1;
        seenP.delete();
        seenOvf.delete();
        applyStimulus(8'd7, 8'd8, 1'b0);
        in_valid = 1'b0;
        tick();
        tick();
        checkOutput("post_rst_early", out_valid, 0);
        tick();
        checkOutput("post_rst_valid", out_valid, 1);
        checkOutput("post_rst_P", out_P, 56);
        repeat (6) tick();
        checkOutput("post_rst_count", seenP.size(), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout actual=running expected=finished");
        $fatal(1, "[TB] timeout");
    end

endmodule
